// File: rtl/seg_pkg.sv
// Shared constants and glyph lookup for the 7-segment scan controller.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_P     = 8'h73;
    localparam logic [7:0] SEG_D     = 8'h5E;

    localparam logic [2:0] DIGIT_P_ONES = 3'd0;
    localparam logic [2:0] DIGIT_P_TENS = 3'd1;
    localparam logic [2:0] DIGIT_GAP_0  = 3'd2;
    localparam logic [2:0] DIGIT_P_CHAR = 3'd3;
    localparam logic [2:0] DIGIT_D_CHAR = 3'd4;
    localparam logic [2:0] DIGIT_GAP_1  = 3'd5;
    localparam logic [2:0] DIGIT_D_ONES = 3'd6;
    localparam logic [2:0] DIGIT_D_TENS = 3'd7;

    // Segments {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
    function automatic logic [7:0] seg_glyph(input logic [3:0] i_digit);
        logic [7:0] r_glyph;
        case (i_digit)
            4'd0:    r_glyph = 8'h3F;
            4'd1:    r_glyph = 8'h06;
            4'd2:    r_glyph = 8'h5B;
            4'd3:    r_glyph = 8'h4F;
            4'd4:    r_glyph = 8'h66;
            4'd5:    r_glyph = 8'h6D;
            4'd6:    r_glyph = 8'h7D;
            4'd7:    r_glyph = 8'h07;
            4'd8:    r_glyph = 8'h7F;
            4'd9:    r_glyph = 8'h6F;
            default: r_glyph = SEG_BLANK;
        endcase
        return r_glyph;
    endfunction

endpackage

// File: rtl/bin5_to_bcd.sv
// Combinational 5-bit binary (0..31) to two-digit BCD.
module bin5_to_bcd (
    input  logic [4:0] i_value,
    output logic [1:0] o_tens,
    output logic [3:0] o_ones
);

    logic [4:0] w_rem;

    always_comb begin
        o_tens = 2'd0;
        w_rem  = i_value;
        if (i_value >= 5'd30) begin
            o_tens = 2'd3;
            w_rem  = i_value - 5'd30;
        end else if (i_value >= 5'd20) begin
            o_tens = 2'd2;
            w_rem  = i_value - 5'd20;
        end else if (i_value >= 5'd10) begin
            o_tens = 2'd1;
            w_rem  = i_value - 5'd10;
        end
        o_ones = w_rem[3:0];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller: player/dealer scores with
// leading-zero blanking and bust blinking, stepped by the divider scan clock.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLINK_FRAMES = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_div_clk,
    input  logic [4:0] i_player_score,
    input  logic [4:0] i_dealer_score,
    input  logic       i_player_bust,
    input  logic       i_dealer_bust,
    output logic [7:0] o_seg_data,
    output logic [7:0] o_seg_com,
    output logic       o_frame_start
);

    localparam logic [2:0] LAST_INDEX = 3'(NUM_DIGITS - 1);
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    logic       r_div_d;
    logic [2:0] r_index;
    logic       r_show;
    logic [7:0] r_seg_data;
    logic [7:0] r_seg_com;
    logic       r_frame_start;
    logic [4:0] r_player;
    logic [4:0] r_dealer;
    logic       r_player_bust;
    logic       r_dealer_bust;
    logic [5:0] r_blink_cnt;
    logic       r_blink;

    logic       w_tick;
    logic       w_frame;
    logic [1:0] w_p_tens;
    logic [3:0] w_p_ones;
    logic [1:0] w_d_tens;
    logic [3:0] w_d_ones;
    logic       w_p_blank;
    logic       w_d_blank;
    logic [7:0] w_pattern;

    assign w_tick  = i_div_clk & ~r_div_d;
    assign w_frame = w_tick && (r_index == LAST_INDEX);

    bin5_to_bcd u_player_bcd (
        .i_value (r_player),
        .o_tens  (w_p_tens),
        .o_ones  (w_p_ones)
    );

    bin5_to_bcd u_dealer_bcd (
        .i_value (r_dealer),
        .o_tens  (w_d_tens),
        .o_ones  (w_d_ones)
    );

    assign w_p_blank = r_player_bust & r_blink;
    assign w_d_blank = r_dealer_bust & r_blink;

    always_comb begin
        w_pattern = SEG_BLANK;
        case (r_index)
            DIGIT_P_ONES: w_pattern = w_p_blank ? SEG_BLANK : seg_glyph(w_p_ones);
            DIGIT_P_TENS: w_pattern = (w_p_blank || w_p_tens == 2'd0) ? SEG_BLANK
                                                                      : seg_glyph({2'b00, w_p_tens});
            DIGIT_P_CHAR: w_pattern = SEG_P;
            DIGIT_D_CHAR: w_pattern = SEG_D;
            DIGIT_D_ONES: w_pattern = w_d_blank ? SEG_BLANK : seg_glyph(w_d_ones);
            DIGIT_D_TENS: w_pattern = (w_d_blank || w_d_tens == 2'd0) ? SEG_BLANK
                                                                      : seg_glyph({2'b00, w_d_tens});
            default:      w_pattern = SEG_BLANK;
        endcase
    end

    // Tick cycle blanks everything so the old digit never ghosts onto the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_d       <= 1'b0;
            r_index       <= 3'd0;
            r_show        <= 1'b0;
            r_seg_data    <= SEG_BLANK;
            r_seg_com     <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_div_d       <= i_div_clk;
            r_frame_start <= w_frame;
            if (w_tick) begin
                r_seg_com  <= 8'hFF;
                r_seg_data <= SEG_BLANK;
                r_index    <= (r_index == LAST_INDEX) ? 3'd0 : r_index + 3'd1;
                r_show     <= 1'b1;
            end else if (r_show) begin
                r_seg_com  <= ~(8'd1 << r_index);
                r_seg_data <= w_pattern;
                r_show     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_player      <= 5'd0;
            r_dealer      <= 5'd0;
            r_player_bust <= 1'b0;
            r_dealer_bust <= 1'b0;
            r_blink_cnt   <= 6'd0;
            r_blink       <= 1'b0;
        end else if (w_frame) begin
            r_player      <= i_player_score;
            r_dealer      <= i_dealer_score;
            r_player_bust <= i_player_bust;
            r_dealer_bust <= i_dealer_bust;
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= 6'd0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 6'd1;
            end
        end
    end

    assign o_seg_data    = r_seg_data;
    assign o_seg_com     = r_seg_com;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: vector table plus reset, blink, tearing and abort sequences.
module tb_seg_scan_ctrl;

    localparam int DIV_HALF = 8;
    localparam int BUDGET   = 400;

    logic       clk;
    logic       rst;
    logic       div_clk;
    logic [4:0] player_score;
    logic [4:0] dealer_score;
    logic       player_bust;
    logic       dealer_bust;
    logic [7:0] seg_data;
    logic [7:0] seg_com;
    logic       frame_start;

    int checks;
    int fails;
    int div_cnt;

    seg_scan_ctrl #(
        .NUM_DIGITS   (8),
        .BLINK_FRAMES (63)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_div_clk      (div_clk),
        .i_player_score (player_score),
        .i_dealer_score (dealer_score),
        .i_player_bust  (player_bust),
        .i_dealer_bust  (dealer_bust),
        .o_seg_data     (seg_data),
        .o_seg_com      (seg_com),
        .o_frame_start  (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scan clock synchronous to clk, changed away from the active edge.
    initial begin
        div_clk = 1'b0;
        div_cnt = 0;
        forever begin
            @(negedge clk);
            if (div_cnt == DIV_HALF - 1) begin
                div_cnt = 0;
                div_clk = ~div_clk;
            end else begin
                div_cnt = div_cnt + 1;
            end
        end
    end

    // At most one digit enable low at any time.
    always @(negedge clk) begin
        checks = checks + 1;
        if ($countones(~seg_com) > 1) begin
            fails = fails + 1;
            $display("FAIL onehot seg_com actual=%h required=at most one bit low", seg_com);
        end
    end

    typedef struct {
        logic [4:0] p;
        logic [4:0] d;
        logic       pb;
        logic       db;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL %s frame_start timeout actual=none required=pulse", name);
        end
    endtask

    task automatic check_digit(input string name, input int idx, input logic [7:0] exp);
        logic [7:0] want_com;
        bit         seen;
        want_com = ~(8'd1 << idx);
        seen     = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (seg_com == want_com) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL %s digit %0d timeout actual=%h required=%h", name, idx, seg_com,
                     want_com);
        end else begin
            check(name, seg_data, exp);
        end
    endtask

    task automatic wait_scan_resume(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (seg_com != 8'hFF) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL %s resume timeout actual=%h required=fd", name, seg_com);
        end else begin
            check({name, "_com"}, seg_com, 8'hFD);
            check({name, "_data"}, seg_data, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] exp6;
        logic [7:0] exp7;
        bit         blank;
        checks       = 0;
        fails        = 0;
        rst          = 1'b0;
        player_score = 5'd0;
        dealer_score = 5'd0;
        player_bust  = 1'b0;
        dealer_bust  = 1'b0;

        vecs[0]  = '{21, 17, 0, 0, 0, 8'h06};
        vecs[1]  = '{21, 17, 0, 0, 1, 8'h5B};
        vecs[2]  = '{21, 17, 0, 0, 2, 8'h00};
        vecs[3]  = '{21, 17, 0, 0, 3, 8'h73};
        vecs[4]  = '{21, 17, 0, 0, 4, 8'h5E};
        vecs[5]  = '{21, 17, 0, 0, 5, 8'h00};
        vecs[6]  = '{21, 17, 0, 0, 6, 8'h07};
        vecs[7]  = '{21, 17, 0, 0, 7, 8'h06};
        vecs[8]  = '{5, 17, 0, 0, 1, 8'h00};
        vecs[9]  = '{5, 17, 0, 0, 0, 8'h6D};
        vecs[10] = '{0, 17, 0, 0, 0, 8'h3F};
        vecs[11] = '{0, 0, 0, 0, 7, 8'h00};
        vecs[12] = '{0, 0, 0, 0, 6, 8'h3F};
        vecs[13] = '{31, 9, 0, 0, 1, 8'h4F};
        vecs[14] = '{31, 9, 0, 0, 0, 8'h06};
        vecs[15] = '{30, 9, 0, 0, 0, 8'h3F};
        vecs[16] = '{10, 9, 0, 0, 7, 8'h00};
        vecs[17] = '{10, 9, 0, 0, 6, 8'h6F};
        vecs[18] = '{10, 28, 0, 0, 7, 8'h5B};
        vecs[19] = '{10, 28, 0, 0, 6, 8'h7F};
        vecs[20] = '{19, 20, 1, 0, 0, 8'h6F};
        vecs[21] = '{19, 20, 0, 1, 7, 8'h5B};

        // Reset state and first tick after release.
        repeat (5) @(negedge clk);
        check("reset_com", seg_com, 8'hFF);
        check("reset_data", seg_data, 8'h00);
        check("reset_fs", {7'd0, frame_start}, 8'h00);
        rst = 1'b1;
        wait_scan_resume("first_tick");

        for (int v = 0; v < 22; v++) begin
            player_score = vecs[v].p;
            dealer_score = vecs[v].d;
            player_bust  = vecs[v].pb;
            dealer_bust  = vecs[v].db;
            wait_frame($sformatf("vec%0d", v));
            check_digit($sformatf("vec%0d", v), vecs[v].idx, vecs[v].exp);
        end

        // Blink: restart counters, dealer bust with 25.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        player_score = 5'd21;
        dealer_score = 5'd25;
        player_bust  = 1'b0;
        dealer_bust  = 1'b1;
        rst          = 1'b1;
        for (int f = 1; f <= 130; f++) begin
            wait_frame($sformatf("blink_f%0d", f));
            if (f == 1 || f == 62 || f == 63 || f == 100 || f == 125 || f == 126) begin
                blank = ((f / 63) % 2) == 1;
                exp6  = blank ? 8'h00 : 8'h6D;
                exp7  = blank ? 8'h00 : 8'h5B;
                check_digit($sformatf("blink_f%0d_p0", f), 0, 8'h06);
                check_digit($sformatf("blink_f%0d_d6", f), 6, exp6);
                check_digit($sformatf("blink_f%0d_d7", f), 7, exp7);
            end
        end

        // Tearing: change mid-frame shows only after the next frame_start.
        dealer_bust  = 1'b0;
        player_score = 5'd12;
        wait_frame("tear_a");
        wait_frame("tear_b");
        check_digit("tear_old_p0", 0, 8'h5B);
        player_score = 5'd7;
        check_digit("tear_old_p1", 1, 8'h06);
        wait_frame("tear_c");
        check_digit("tear_new_p0", 0, 8'h07);
        check_digit("tear_new_p1", 1, 8'h00);

        // Abort at index 4.
        wait_frame("abort");
        check_digit("abort_d4", 4, 8'h5E);
        rst = 1'b0;
        #1;
        check("abort_com", seg_com, 8'hFF);
        check("abort_data", seg_data, 8'h00);
        repeat (3) @(negedge clk);
        check("abort_fs", {7'd0, frame_start}, 8'h00);
        rst = 1'b1;
        wait_scan_resume("abort_resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
